e_pipe_reg: RTL

E_PIPE_REG -- requirements
Module: e_pipe_reg

---
 rtl/e_pipe_reg.sv | 117 +++++++++++
 1 files changed

// File: rtl/e_pipe_reg.sv
// Decode-to-execute pipeline register with stall/bubble control, load-use
// hazard detection, a saturating bubble counter and a sticky control-conflict flag.
module e_pipe_reg #(
    parameter logic [4:0]  RNONE    = 5'd0,
    parameter logic [15:0] NOP_CTRL = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        E_stall,
    input  logic        E_bubble,
    input  logic [15:0] d_ctrl,
    input  logic [31:0] d_valA,
    input  logic [31:0] d_valB,
    input  logic [31:0] d_valC,
    input  logic [31:0] d_pc,
    input  logic [4:0]  d_srcA,
    input  logic [4:0]  d_srcB,
    input  logic [4:0]  d_dstE,
    input  logic [4:0]  d_dstM,
    output logic [15:0] E_ctrl,
    output logic [31:0] E_valA,
    output logic [31:0] E_valB,
    output logic [31:0] E_valC,
    output logic [31:0] E_pc,
    output logic [4:0]  E_srcA,
    output logic [4:0]  E_srcB,
    output logic [4:0]  E_dstE,
    output logic [4:0]  E_dstM,
    output logic        d_loaduse,
    output logic [15:0] bubble_cnt,
    output logic        ctrl_err
);

    typedef struct packed {
        logic [15:0] ctrl;
        logic [31:0] valA;
        logic [31:0] valB;
        logic [31:0] valC;
        logic [31:0] pc;
        logic [4:0]  srcA;
        logic [4:0]  srcB;
        logic [4:0]  dstE;
        logic [4:0]  dstM;
    } eBundle_t;

    localparam eBundle_t NOP_BUNDLE = '{
        ctrl: NOP_CTRL,
        valA: 32'd0,
        valB: 32'd0,
        valC: 32'd0,
        pc:   32'd0,
        srcA: RNONE,
        srcB: RNONE,
        dstE: RNONE,
        dstM: RNONE
    };

    eBundle_t    eReg;
    eBundle_t    dIn;
    logic [15:0] bubbleCnt;
    logic        ctrlErr;

    always_comb begin
        dIn      = NOP_BUNDLE;
        dIn.ctrl = d_ctrl;
        dIn.valA = d_valA;
        dIn.valB = d_valB;
        dIn.valC = d_valC;
        dIn.pc   = d_pc;
        dIn.srcA = d_srcA;
        dIn.srcB = d_srcB;
        dIn.dstE = d_dstE;
        dIn.dstM = d_dstM;
    end

    // Bubble wins over stall; a stall simply keeps eReg as is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eReg <= NOP_BUNDLE;
        end else if (E_bubble) begin
            eReg <= NOP_BUNDLE;
        end else if (!E_stall) begin
            eReg <= dIn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubbleCnt <= 16'd0;
            ctrlErr   <= 1'b0;
        end else begin
            if (E_bubble && (bubbleCnt != 16'hFFFF))
                bubbleCnt <= bubbleCnt + 16'd1;
            if (E_bubble && E_stall)
                ctrlErr <= 1'b1;
        end
    end

    // A load in E whose destination feeds either decode source must stall decode.
    always_comb begin
        d_loaduse = (eReg.dstM != RNONE) &&
                    ((eReg.dstM == d_srcA) || (eReg.dstM == d_srcB));
    end

    assign E_ctrl     = eReg.ctrl;
    assign E_valA     = eReg.valA;
    assign E_valB     = eReg.valB;
    assign E_valC     = eReg.valC;
    assign E_pc       = eReg.pc;
    assign E_srcA     = eReg.srcA;
    assign E_srcB     = eReg.srcB;
    assign E_dstE     = eReg.dstE;
    assign E_dstM     = eReg.dstM;
    assign bubble_cnt = bubbleCnt;
    assign ctrl_err   = ctrlErr;

endmodule
